instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the pipelined RV32I core. It owns the program counter and drives the instruction memory's asynchronous read address. It captures the returned word into the IF/ID pipeline register, alongside its PC and a valid bit. It honours a downstream stall, accepts a redirect (branch/jump/flush) from later stages, and freezes fetch after an `ecall` until a redirect clears it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `NOP_INST`, default 32'h0000_0013: encoding placed in `if_id_inst` for bubbles (`addi x0,x0,0`).
- `ECALL_INST`, default 32'h0000_0073: encoding that triggers fetch freeze.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  current PC; combinational copy of the PC register, feeds instruction memory.
- `imem_dout`  in  32  instruction word returned asynchronously for `imem_addr`, same cycle.
- `stall`  in  1  downstream hazard; hold PC and IF/ID unchanged.
- `redirect`  in  1  control-flow change or flush from EX/MEM.
- `redirect_target`  in  32  new PC when `redirect`=1; bits [1:0] ignored and treated as 0.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_inst`  out  32  latched instruction.
- `if_id_pc`  out  32  PC of the latched instruction.
- `fetch_frozen`  out  1  an `ecall` has been fetched; no further fetch until redirect.
- `fetch_count`  out  32  number of instructions delivered with valid=1 since reset; wraps mod 2^32.

## Operation
- Registers: `pc`, `if_id_inst`, `if_id_pc`, `if_id_valid`, `fetch_frozen`, `fetch_count`. All outputs are registered except `imem_addr`, which equals `pc`.
- Priority at each rising edge: reset > redirect > stall > frozen > normal fetch.
- **Reset**
  - `pc`=`RESET_PC`, `if_id_valid`=0, `if_id_inst`=`NOP_INST`, `if_id_pc`=0, `fetch_frozen`=0, `fetch_count`=0.
- **Redirect**
  - `pc` ← {`redirect_target`[31:2],2'b00}.
  - `if_id_valid` ← 0, `if_id_inst` ← `NOP_INST`, `if_id_pc` ← 0, `fetch_frozen` ← 0.
  - The count is not incremented.
  - A redirect overrides a simultaneous `stall` and a frozen state.
- **Stall** (no redirect): every register holds its value, including `fetch_count`.
- **Frozen** (no redirect, no stall):
  - `pc` holds.
  - `if_id_valid` ← 0, `if_id_inst` ← `NOP_INST`.
  - `if_id_pc` holds.
  - The count holds.
- **Normal fetch**:
  - `if_id_inst` ← `imem_dout`, `if_id_pc` ← `pc`, `if_id_valid` ← 1, `fetch_count` ← `fetch_count`+1.
  - If `imem_dout`==`ECALL_INST`: `fetch_frozen` ← 1 and `pc` holds (still the ecall address).
  - Otherwise `pc` ← `pc`+4.
- **Arithmetic**
  - `pc`+4 is 32-bit modulo: 32'hFFFF_FFFC → 32'h0000_0000.
  - `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- The block does no address range checking. Instruction memory indexes with `pc`[11:2] and aliases above its depth.

## Timing
- Fetch latency is one cycle. The word at `pc` during cycle N appears on `if_id_inst` with `if_id_valid`=1 after edge N+1.
- Throughput is one instruction per cycle when not stalled, frozen or redirected.
- After reset deasserts, the first valid instruction (address `RESET_PC`) appears one edge later.
- Redirect asserted in cycle N:
  - `imem_addr`=target from cycle N+1.
  - IF/ID holds a bubble during cycle N+1.
  - Target instruction is valid after edge N+2.
- Stall asserted for K cycles freezes outputs for exactly K edges. The instruction presented before the stall is not lost or duplicated.
- Reset asserted mid-operation overrides everything at that edge, including a pending redirect or frozen state.
- `redirect_target` is sampled only when `redirect`=1. `imem_dout` is sampled only on a normal-fetch edge.

## Test plan
- **Sequential fetch**
  - Stimulus: memory 0x0..0xC = 0x00500093, 0x00a00113, 0x002081b3, 0x00000013; reset 2 cycles then release.
  - Required: `if_id_pc`=0,4,8,C on consecutive cycles with valid=1, matching words, `fetch_count`=4.
- **Stall**
  - Stimulus: assert `stall` for 3 cycles while `if_id_pc`=4.
  - Required: `if_id_pc`=4, inst and valid unchanged for 3 edges; then 8 follows with no skip or duplicate; count unchanged during the stall.
- **Redirect**
  - Stimulus: `redirect`=1 with target 0x0000_0042 while `pc`=0x10.
  - Required: next `imem_addr`=0x40; one bubble (valid=0, inst=0x00000013); then `if_id_pc`=0x40 valid.
- **Redirect + stall same cycle**
  - Required: redirect wins; `pc`=target, bubble inserted.
- **Ecall freeze**
  - Stimulus: word 0x00000073 at 0x8.
  - Required: `if_id_pc`=8 valid once, `fetch_frozen`=1, `imem_addr` stays 8, following cycles valid=0.
  - Then redirect to 0x20: frozen clears and fetch resumes at 0x20.
- **Wrap and reset mid-run**
  - Stimulus: redirect to 0xFFFF_FFFC and fetch a non-ecall word.
  - Required: next `imem_addr`=0.
  - Then assert reset while frozen: all outputs return to reset values at that edge.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   Fetch stage of the pipelined RV32I core. Owns the program counter, drives
//   the asynchronous instruction-memory address and captures the returned
//   word into the IF/ID pipeline register together with its PC and a valid
//   bit. Honours downstream stalls and redirects, and stops fetching once an
//   ecall has been fetched until a redirect releases it.
//
// Ports
//   clk, reset        clock / synchronous active-high reset
//   imem_addr         current PC (combinational copy of the PC register)
//   imem_dout         instruction word for imem_addr, same cycle
//   stall             hold PC and IF/ID
//   redirect          load redirect_target (low two bits forced to 0)
//   redirect_target   new PC on redirect
//   if_id_valid       IF/ID holds a real instruction
//   if_id_inst        latched instruction (NOP_INST for bubbles)
//   if_id_pc          PC of the latched instruction
//   fetch_frozen      ecall fetched, waiting for redirect
//   fetch_count       instructions delivered with valid=1 since reset
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [31:0] ECALL_INST = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        fetch_frozen,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_FROZEN = 1'b1
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_inst, w_inst_next;
  logic [31:0] r_if_pc, w_if_pc_next;
  logic        r_valid, w_valid_next;
  logic [31:0] r_count, w_count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_if_pc <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_inst  <= w_inst_next;
      r_if_pc <= w_if_pc_next;
      r_valid <= w_valid_next;
      r_count <= w_count_next;
    end
  end

  // Priority below reset: redirect > stall > frozen > normal fetch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_inst_next  = r_inst;
    w_if_pc_next = r_if_pc;
    w_valid_next = r_valid;
    w_count_next = r_count;
    if (redirect) begin
      w_state_next = S_FETCH;
      w_pc_next    = {redirect_target[31:2], 2'b00};
      w_inst_next  = NOP_INST;
      w_if_pc_next = '0;
      w_valid_next = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (r_state == S_FROZEN) begin
      // bubble out, but keep if_id_pc pointing at the ecall
      w_inst_next  = NOP_INST;
      w_valid_next = 1'b0;
    end else begin
      w_inst_next  = imem_dout;
      w_if_pc_next = r_pc;
      w_valid_next = 1'b1;
      w_count_next = r_count + 32'd1;
      if (imem_dout == ECALL_INST) begin
        w_state_next = S_FROZEN;
      end else begin
        w_pc_next = r_pc + 32'd4;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign if_id_valid  = r_valid;
  assign if_id_inst   = r_inst;
  assign if_id_pc     = r_if_pc;
  assign fetch_frozen = (r_state == S_FROZEN);
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        fetch_frozen;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model state
  logic [31:0] m_pc, m_inst, m_ifpc, m_count;
  logic        m_valid, m_frozen;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr[11:2]];

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INST  (NOP),
    .ECALL_INST(ECALL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .fetch_frozen   (fetch_frozen),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the program as the pipeline should see it, using the
  // model's own PC to read the bench memory.
  always @(posedge clk) begin
    logic [31:0] word;
    word = mem[m_pc[11:2]];
    if (reset) begin
      m_pc = 32'h0; m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
      m_frozen = 1'b0; m_count = 32'h0;
    end else if (redirect) begin
      m_pc = redirect_target & 32'hFFFF_FFFC;
      m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0; m_frozen = 1'b0;
    end else if (stall) begin
      // nothing changes
    end else if (m_frozen) begin
      m_inst = NOP; m_valid = 1'b0;
    end else begin
      m_inst = word; m_ifpc = m_pc; m_valid = 1'b1; m_count = m_count + 1;
      if (word == ECALL) m_frozen = 1'b1;
      else m_pc = m_pc + 4;
    end
  end

  // Compare process: every cycle once the model is defined.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.imem_addr", imem_addr, m_pc);
      chk("m.if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("m.if_id_inst", if_id_inst, m_inst);
      chk("m.if_id_pc", if_id_pc, m_ifpc);
      chk("m.fetch_frozen", {31'b0, fetch_frozen}, {31'b0, m_frozen});
      chk("m.fetch_count", fetch_count, m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
    mem[2] = 32'h0020_81b3;
    mem[3] = 32'h0000_0013;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

    // reset for two edges
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst.valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst.inst", if_id_inst, NOP);
    chk("rst.count", fetch_count, 32'd0);
    chk("rst.addr", imem_addr, 32'h0);

    // sequential fetch with a 3-cycle stall at pc 4
    reset = 1'b0;
    tick();
    chk("seq.pc0", if_id_pc, 32'h0);
    chk("seq.inst0", if_id_inst, 32'h0050_0093);
    chk("seq.valid0", {31'b0, if_id_valid}, 32'd1);
    tick();
    chk("seq.pc4", if_id_pc, 32'h4);
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall.pc", if_id_pc, 32'h4);
      chk("stall.inst", if_id_inst, 32'h00a0_0113);
      chk("stall.count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("seq.pc8", if_id_pc, 32'h8);
    chk("seq.inst8", if_id_inst, 32'h0020_81b3);
    tick();
    chk("seq.pcC", if_id_pc, 32'hC);
    chk("seq.count", fetch_count, 32'd4);
    chk("seq.addr10", imem_addr, 32'h10);

    // redirect to 0x42 -> 0x40
    redirect = 1'b1; redirect_target = 32'h0000_0042;
    tick();
    redirect = 1'b0;
    chk("redir.addr", imem_addr, 32'h40);
    chk("redir.bubble_valid", {31'b0, if_id_valid}, 32'd0);
    chk("redir.bubble_inst", if_id_inst, NOP);
    tick();
    chk("redir.pc", if_id_pc, 32'h40);
    chk("redir.valid", {31'b0, if_id_valid}, 32'd1);

    // redirect wins over stall
    redirect = 1'b1; stall = 1'b1; redirect_target = 32'h0000_0100;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("rs.addr", imem_addr, 32'h100);
    chk("rs.valid", {31'b0, if_id_valid}, 32'd0);

    // ecall at 0x8
    mem[2] = ECALL;
    redirect = 1'b1; redirect_target = 32'h0;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    chk("ecall.pc", if_id_pc, 32'h8);
    chk("ecall.valid", {31'b0, if_id_valid}, 32'd1);
    chk("ecall.frozen", {31'b0, fetch_frozen}, 32'd1);
    chk("ecall.addr", imem_addr, 32'h8);
    repeat (2) tick();
    chk("frz.valid", {31'b0, if_id_valid}, 32'd0);
    chk("frz.pc", if_id_pc, 32'h8);
    chk("frz.addr", imem_addr, 32'h8);
    redirect = 1'b1; redirect_target = 32'h20;
    tick();
    redirect = 1'b0;
    chk("unfrz.frozen", {31'b0, fetch_frozen}, 32'd0);
    chk("unfrz.addr", imem_addr, 32'h20);
    tick();
    chk("unfrz.pc", if_id_pc, 32'h20);

    // PC wrap
    mem[1023] = NOP;
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap.addr0", imem_addr, 32'h0);
    chk("wrap.pc", if_id_pc, 32'hFFFF_FFFC);

    // freeze again, then reset while frozen
    redirect = 1'b1; redirect_target = 32'h8;
    tick();
    redirect = 1'b0;
    tick();
    chk("rf.frozen", {31'b0, fetch_frozen}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rf.frozen0", {31'b0, fetch_frozen}, 32'd0);
    chk("rf.valid", {31'b0, if_id_valid}, 32'd0);
    chk("rf.inst", if_id_inst, NOP);
    chk("rf.pc", if_id_pc, 32'h0);
    chk("rf.count", fetch_count, 32'd0);
    chk("rf.addr", imem_addr, 32'h0);
    reset = 1'b0;

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? ECALL : $urandom;
    for (int n = 0; n < 3000; n++) begin
      stall           = ($urandom_range(0, 3) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      reset           = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
